axis_proc_scheduler: RTL and testbench

AXIS_PROC_SCHEDULER -- requirements
Module: axis_proc_scheduler

---
 rtl/axis_proc_scheduler_pkg.sv | 37 +++
 rtl/axis_rr_arbiter2.sv | 31 +++
 rtl/axis_proc_scheduler.sv | 240 ++++++++++++++++++++++++
 tb/tb_axis_proc_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_proc_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// axis_proc_scheduler_pkg
// Shared definitions for the two-source AXI-Stream packet scheduler:
//   - default widths for the stream data and the per-source packet counters
//   - processor mode encodings driven on proc_mode
//   - scheduler FSM state type
//   - norm_mode(): folds the reserved mode encoding onto pass-through
// -----------------------------------------------------------------------------
package axis_proc_scheduler_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_BREV = 2'b01,
    MODE_ADD  = 2'b10
  } proc_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } sched_state_e;

  // The reserved encoding 2'b11 behaves as pass-through, so it is never
  // presented to the processor.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    logic [1:0] result;
    case (mode)
      MODE_BREV: result = MODE_BREV;
      MODE_ADD:  result = MODE_ADD;
      default:   result = MODE_PASS;
    endcase
    return result;
  endfunction

endpackage : axis_proc_scheduler_pkg

// File: rtl/axis_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter2
// Purely combinational two-way round-robin arbiter.
//   req[1:0]   in   request per source
//   last_grant in   index of the most recently granted source
//   gnt_valid  out  at least one request present
//   gnt_idx    out  winning source index
// With both sources requesting, the source that did not win last time is
// chosen; with a single request, that source wins regardless of history.
// -----------------------------------------------------------------------------
module axis_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // NOTE: every output of a combinational block gets a default at the top so
  // that no path through the block leaves it unassigned (which would infer a
  // latch).
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    if (&req) begin
      gnt_idx = ~last_grant;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule : axis_rr_arbiter2

// File: rtl/axis_proc_scheduler.sv
// -----------------------------------------------------------------------------
// axis_proc_scheduler
// Packet-level round-robin scheduler that forwards one of two AXI-Stream
// sources to a shared stream processor, together with that source's
// processor configuration.
//
// Ports
//   aclk, areset                  clock, asynchronous active-low reset
//   s0_axis_*, s1_axis_*          source AXI-Stream slaves (tvalid/tready/
//                                 tdata/tkeep/tstrb/tlast)
//   cfg_mode0/1, cfg_add0/1       per-source processor mode and add constant
//   m_axis_*                      AXI-Stream master toward the processor;
//                                 m_axis_tuser carries the owning source index
//   proc_mode, proc_add_value     configuration of the packet being forwarded
//   pkt_cnt0/1                    completed packets per source (wrapping)
//   busy                          high while a packet grant is held
//
// A grant is taken in IDLE and held until the tlast beat of the granted source
// is accepted; configuration is captured at grant time and stays frozen for
// the whole packet. Beats pass through a single output register, giving one
// cycle of latency and full throughput while m_axis_tready is high.
// -----------------------------------------------------------------------------
module axis_proc_scheduler
  import axis_proc_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                    aclk,
  input  logic                    areset,

  input  logic                    s0_axis_tvalid,
  output logic                    s0_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axis_tkeep,
  input  logic [DATA_WIDTH/8-1:0] s0_axis_tstrb,
  input  logic                    s0_axis_tlast,

  input  logic                    s1_axis_tvalid,
  output logic                    s1_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axis_tkeep,
  input  logic [DATA_WIDTH/8-1:0] s1_axis_tstrb,
  input  logic                    s1_axis_tlast,

  input  logic [1:0]              cfg_mode0,
  input  logic [1:0]              cfg_mode1,
  input  logic [DATA_WIDTH-1:0]   cfg_add0,
  input  logic [DATA_WIDTH-1:0]   cfg_add1,

  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,

  output logic [1:0]              proc_mode,
  output logic [DATA_WIDTH-1:0]   proc_add_value,
  output logic [CNT_WIDTH-1:0]    pkt_cnt0,
  output logic [CNT_WIDTH-1:0]    pkt_cnt1,
  output logic                    busy
);

  localparam int BYTES = DATA_WIDTH / 8;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  sched_state_e          r_state;
  sched_state_e          w_state_nxt;

  logic                  r_ptr;     // last-granted source
  logic                  r_grant;   // source owning the current grant
  logic [1:0]            r_mode;
  logic [DATA_WIDTH-1:0] r_add;

  logic                  r_m_tvalid;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic [BYTES-1:0]      r_m_tkeep;
  logic [BYTES-1:0]      r_m_tstrb;
  logic                  r_m_tlast;
  logic                  r_m_tuser;

  logic [CNT_WIDTH-1:0]  r_cnt0;
  logic [CNT_WIDTH-1:0]  r_cnt1;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic w_arb_valid;
  logic w_arb_idx;

  axis_rr_arbiter2 u_arbiter (
    .req        ({s1_axis_tvalid, s0_axis_tvalid}),
    .last_grant (r_ptr),
    .gnt_valid  (w_arb_valid),
    .gnt_idx    (w_arb_idx)
  );

  // ---------------------------------------------------------------------------
  // Handshake datapath
  // ---------------------------------------------------------------------------
  logic                  w_out_free;    // output register can take a beat
  logic                  w_grant_ready; // granted source may transfer
  logic                  w_sel_valid;
  logic [DATA_WIDTH-1:0] w_sel_tdata;
  logic [BYTES-1:0]      w_sel_tkeep;
  logic [BYTES-1:0]      w_sel_tstrb;
  logic                  w_sel_tlast;
  logic                  w_accept;      // beat transferred from granted source
  logic                  w_take_grant;  // IDLE -> GRANT this cycle
  logic                  w_release;     // tlast beat transferred this cycle

  // The output register accepts a new beat when empty or when it drains in
  // the same cycle, which sustains one beat per cycle.
  assign w_out_free    = !r_m_tvalid || m_axis_tready;
  assign w_grant_ready = (r_state == ST_GRANT) && w_out_free;

  assign s0_axis_tready = w_grant_ready && !r_grant;
  assign s1_axis_tready = w_grant_ready &&  r_grant;

  always_comb begin
    w_sel_valid = s0_axis_tvalid;
    w_sel_tdata = s0_axis_tdata;
    w_sel_tkeep = s0_axis_tkeep;
    w_sel_tstrb = s0_axis_tstrb;
    w_sel_tlast = s0_axis_tlast;
    if (r_grant) begin
      w_sel_valid = s1_axis_tvalid;
      w_sel_tdata = s1_axis_tdata;
      w_sel_tkeep = s1_axis_tkeep;
      w_sel_tstrb = s1_axis_tstrb;
      w_sel_tlast = s1_axis_tlast;
    end
  end

  assign w_accept     = w_sel_valid && w_grant_ready;
  assign w_release    = w_accept && w_sel_tlast;
  assign w_take_grant = (r_state == ST_IDLE) && w_arb_valid;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A source dropping tvalid mid-packet keeps the grant; only the accepted
  // tlast beat releases it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_take_grant) w_state_nxt = ST_GRANT;
      ST_GRANT: if (w_release)    w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Grant and configuration capture (frozen for the whole packet)
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      r_ptr   <= 1'b1;  // source 0 wins the first contention
      r_grant <= 1'b0;
      r_mode  <= MODE_PASS;
      r_add   <= '0;
    end else if (w_take_grant) begin
      r_ptr   <= w_arb_idx;
      r_grant <= w_arb_idx;
      r_mode  <= norm_mode(w_arb_idx ? cfg_mode1 : cfg_mode0);
      r_add   <= w_arb_idx ? cfg_add1 : cfg_add0;
    end
  end

  // ---------------------------------------------------------------------------
  // One-entry output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tstrb  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= 1'b0;
    end else if (w_accept) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= w_sel_tdata;
      r_m_tkeep  <= w_sel_tkeep;
      r_m_tstrb  <= w_sel_tstrb;
      r_m_tlast  <= w_sel_tlast;
      r_m_tuser  <= r_grant;
    end else if (m_axis_tready) begin
      // Payload is left as-is; only the valid flag drops once drained.
      r_m_tvalid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-source completed-packet counters (wrap naturally)
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_release) begin
      if (r_grant) begin
        r_cnt1 <= r_cnt1 + CNT_WIDTH'(1);
      end else begin
        r_cnt0 <= r_cnt0 + CNT_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign m_axis_tvalid  = r_m_tvalid;
  assign m_axis_tdata   = r_m_tdata;
  assign m_axis_tkeep   = r_m_tkeep;
  assign m_axis_tstrb   = r_m_tstrb;
  assign m_axis_tlast   = r_m_tlast;
  assign m_axis_tuser   = r_m_tuser;

  assign proc_mode      = r_mode;
  assign proc_add_value = r_add;
  assign pkt_cnt0       = r_cnt0;
  assign pkt_cnt1       = r_cnt1;
  assign busy           = (r_state == ST_GRANT);

endmodule : axis_proc_scheduler

// File: tb/tb_axis_proc_scheduler.sv
// -----------------------------------------------------------------------------
// tb_axis_proc_scheduler
// Directed bench for axis_proc_scheduler (CNT_WIDTH=4 so counter wrap is
// reachable). Expected output beats, including owning source and the
// processor configuration they must travel with, are queued in the order the
// round-robin rules dictate; a monitor pops and compares on every m_axis
// handshake. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_axis_proc_scheduler;

  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int CW = 4;
  localparam int LIMIT = 200;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [BW-1:0] keep;
    logic [BW-1:0] strb;
    logic          last;
    logic          user;
    logic [1:0]    mode;
    logic [DW-1:0] add;
  } exp_t;

  logic          aclk = 1'b0;
  logic          areset = 1'b0;
  logic          s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
  logic [DW-1:0] s0_axis_tdata;
  logic [BW-1:0] s0_axis_tkeep, s0_axis_tstrb;
  logic          s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
  logic [DW-1:0] s1_axis_tdata;
  logic [BW-1:0] s1_axis_tkeep, s1_axis_tstrb;
  logic [1:0]    cfg_mode0, cfg_mode1;
  logic [DW-1:0] cfg_add0, cfg_add1;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [DW-1:0] m_axis_tdata;
  logic [BW-1:0] m_axis_tkeep, m_axis_tstrb;
  logic [1:0]    proc_mode;
  logic [DW-1:0] proc_add_value;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;
  logic          busy;

  axis_proc_scheduler #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .aclk           (aclk),
    .areset         (areset),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tready (s0_axis_tready),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tkeep  (s0_axis_tkeep),
    .s0_axis_tstrb  (s0_axis_tstrb),
    .s0_axis_tlast  (s0_axis_tlast),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tready (s1_axis_tready),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tkeep  (s1_axis_tkeep),
    .s1_axis_tstrb  (s1_axis_tstrb),
    .s1_axis_tlast  (s1_axis_tlast),
    .cfg_mode0      (cfg_mode0),
    .cfg_mode1      (cfg_mode1),
    .cfg_add0       (cfg_add0),
    .cfg_add1       (cfg_add1),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tstrb   (m_axis_tstrb),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .proc_mode      (proc_mode),
    .proc_add_value (proc_add_value),
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1),
    .busy           (busy)
  );

  always #5 aclk = ~aclk;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  logic [CW-1:0] exp_cnt0 = '0;
  logic [CW-1:0] exp_cnt1 = '0;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Keep narrows on the last beat so tkeep/tstrb routing is exercised.
  function automatic logic [BW-1:0] keep_of(input logic last);
    return last ? 4'h7 : 4'hF;
  endfunction

  task automatic push(input logic [DW-1:0] data, input logic last, input logic user,
                      input logic [1:0] mode, input logic [DW-1:0] add);
    exp_t e;
    e.data = data; e.keep = keep_of(last); e.strb = keep_of(last);
    e.last = last; e.user = user; e.mode = mode; e.add = add;
    sb.push_back(e);
  endtask

  task automatic set_src(input int src, input logic valid, input logic [DW-1:0] data,
                         input logic last);
    if (src == 0) begin
      s0_axis_tvalid = valid; s0_axis_tdata = data; s0_axis_tlast = last;
      s0_axis_tkeep = keep_of(last); s0_axis_tstrb = keep_of(last);
    end else begin
      s1_axis_tvalid = valid; s1_axis_tdata = data; s1_axis_tlast = last;
      s1_axis_tkeep = keep_of(last); s1_axis_tstrb = keep_of(last);
    end
  endtask

  // Returns 1 time unit after the edge on which the beat was taken.
  task automatic wait_accept(input int src);
    int  k = 0;
    bit  done = 0;
    while (!done && k < LIMIT) begin
      @(negedge aclk);
      if ((src == 0) ? s0_axis_tready : s1_axis_tready) begin
        @(posedge aclk);
        #1;
        done = 1;
      end
      k++;
    end
    check($sformatf("src%0d_accept_in_time", src), 64'(done), 64'd1);
  endtask

  task automatic send_pkt(input int src, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d0 : (i == 1) ? d1 : d2;
      set_src(src, 1'b1, d, i == n - 1);
      wait_accept(src);
    end
    set_src(src, 1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || m_axis_tvalid || busy) && k < LIMIT) begin
      @(negedge aclk);
      k++;
    end
    check("drain_in_time", 64'(k < LIMIT), 64'd1);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    @(posedge aclk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    check({tag, "_m_payload"},
          64'({m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tlast, m_axis_tuser}), 64'd0);
    check({tag, "_s_tready"}, 64'({s0_axis_tready, s1_axis_tready}), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_proc_mode"}, 64'(proc_mode), 64'd0);
    check({tag, "_proc_add"}, 64'(proc_add_value), 64'd0);
    check({tag, "_pkt_cnt"}, 64'({pkt_cnt0, pkt_cnt1}), 64'd0);
  endtask

  // Scoreboard monitor: a handshake happens on the next rising edge.
  always @(negedge aclk) begin
    if (areset && m_axis_tvalid && m_axis_tready) begin
      exp_t e;
      check("beat_expected", 64'(sb.size() != 0), 64'd1);
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      check("beat_data", 64'(m_axis_tdata), 64'(e.data));
      check("beat_keep_strb_last_user",
            64'({m_axis_tkeep, m_axis_tstrb, m_axis_tlast, m_axis_tuser}),
            64'({e.keep, e.strb, e.last, e.user}));
      check("beat_proc_mode", 64'(proc_mode), 64'(e.mode));
      check("beat_proc_add", 64'(proc_add_value), 64'(e.add));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_src(0, 1'b0, '0, 1'b0);
    set_src(1, 1'b0, '0, 1'b0);
    cfg_mode0 = 2'b00; cfg_mode1 = 2'b00; cfg_add0 = '0; cfg_add1 = '0;
    m_axis_tready = 1'b1;

    // Reset values while areset is held low.
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge aclk);
    areset = 1'b1;
    @(posedge aclk); #1;

    // Single packet on s0, byte-reversal mode, with first-beat latency.
    cfg_mode0 = 2'b01; cfg_add0 = 32'h0000_0010;
    push(32'hDEAD_BEEF, 1'b0, 1'b0, 2'b01, 32'h0000_0010);
    push(32'h1234_5678, 1'b1, 1'b0, 2'b01, 32'h0000_0010);
    fork
      send_pkt(0, 32'hDEAD_BEEF, 32'h1234_5678, '0, 2);
      begin
        @(negedge aclk);
        check("lat_idle_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("lat_idle_busy", 64'(busy), 64'd0);
        @(negedge aclk);
        check("lat_grant_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("lat_grant_busy", 64'(busy), 64'd1);
        @(negedge aclk);
        check("lat_first_beat_tvalid", 64'(m_axis_tvalid), 64'd1);
      end
    join
    exp_cnt0++;
    drain();
    check("single_pkt_cnt0", 64'(pkt_cnt0), 64'(exp_cnt0));

    // Config freeze on s1: cfg_add1 changes while beat 3 is pending.
    cfg_mode1 = 2'b10; cfg_add1 = 32'h0000_0001;
    push(32'h0101_0001, 1'b0, 1'b1, 2'b10, 32'h0000_0001);
    push(32'h0101_0002, 1'b0, 1'b1, 2'b10, 32'h0000_0001);
    push(32'h0101_0003, 1'b1, 1'b1, 2'b10, 32'h0000_0001);
    fork
      send_pkt(1, 32'h0101_0001, 32'h0101_0002, 32'h0101_0003, 3);
      begin
        repeat (3) @(posedge aclk);
        #2 cfg_add1 = 32'h0000_0005;
        #1 check("freeze_add_mid_pkt", 64'(proc_add_value), 64'h1);
      end
    join
    exp_cnt1++;
    drain();
    push(32'h0202_0001, 1'b1, 1'b1, 2'b10, 32'h0000_0005);
    send_pkt(1, 32'h0202_0001, '0, '0, 1);
    exp_cnt1++;
    drain();
    check("freeze_pkt_cnt1", 64'(pkt_cnt1), 64'(exp_cnt1));

    // Contention: last grant was s1, so s0 goes first, then strict alternation.
    cfg_mode0 = 2'b00; cfg_add0 = 32'h0000_00A0;
    cfg_mode1 = 2'b01; cfg_add1 = 32'h0000_00B0;
    push(32'hA000_0001, 1'b0, 1'b0, 2'b00, 32'h0000_00A0);
    push(32'hA000_0002, 1'b1, 1'b0, 2'b00, 32'h0000_00A0);
    push(32'hB000_0001, 1'b0, 1'b1, 2'b01, 32'h0000_00B0);
    push(32'hB000_0002, 1'b1, 1'b1, 2'b01, 32'h0000_00B0);
    push(32'hC000_0001, 1'b0, 1'b0, 2'b00, 32'h0000_00A0);
    push(32'hC000_0002, 1'b1, 1'b0, 2'b00, 32'h0000_00A0);
    push(32'hD000_0001, 1'b0, 1'b1, 2'b01, 32'h0000_00B0);
    push(32'hD000_0002, 1'b1, 1'b1, 2'b01, 32'h0000_00B0);
    fork
      begin
        send_pkt(0, 32'hA000_0001, 32'hA000_0002, '0, 2);
        send_pkt(0, 32'hC000_0001, 32'hC000_0002, '0, 2);
      end
      begin
        send_pkt(1, 32'hB000_0001, 32'hB000_0002, '0, 2);
        send_pkt(1, 32'hD000_0001, 32'hD000_0002, '0, 2);
      end
    join
    exp_cnt0 += 2;
    exp_cnt1 += 2;
    drain();
    check("contend_pkt_cnt", 64'({pkt_cnt0, pkt_cnt1}), 64'({exp_cnt0, exp_cnt1}));

    // Backpressure: ABCDEF01 held for 5 cycles with every source stalled.
    cfg_mode0 = 2'b00; cfg_add0 = 32'h0000_000C;
    m_axis_tready = 1'b0;
    push(32'hABCD_EF01, 1'b0, 1'b0, 2'b00, 32'h0000_000C);
    push(32'h0000_0002, 1'b1, 1'b0, 2'b00, 32'h0000_000C);
    fork
      send_pkt(0, 32'hABCD_EF01, 32'h0000_0002, '0, 2);
      begin
        int k = 0;
        do begin
          @(negedge aclk);
          k++;
        end while (!m_axis_tvalid && k < LIMIT);
        check("bp_beat_registered", 64'(m_axis_tvalid), 64'd1);
        repeat (5) begin
          @(negedge aclk);
          check("bp_tvalid_held", 64'(m_axis_tvalid), 64'd1);
          check("bp_payload_held",
                64'({m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tlast, m_axis_tuser}),
                64'({32'hABCD_EF01, 4'hF, 4'hF, 1'b0, 1'b0}));
          check("bp_s_tready_low", 64'({s0_axis_tready, s1_axis_tready}), 64'd0);
        end
        @(posedge aclk); #1;
        m_axis_tready = 1'b1;
      end
    join
    exp_cnt0++;
    drain();
    check("bp_pkt_cnt0", 64'(pkt_cnt0), 64'(exp_cnt0));

    // Reset after beat 1 of 3 on s0: that beat and the grant are discarded.
    cfg_mode1 = 2'b00; cfg_add1 = 32'h0000_0033;
    set_src(0, 1'b1, 32'h1111_1111, 1'b0);
    wait_accept(0);
    areset = 1'b0;
    #1;
    check_reset_outputs("midpkt_reset");
    exp_cnt0 = '0;
    exp_cnt1 = '0;
    set_src(0, 1'b0, '0, 1'b0);
    @(negedge aclk);
    areset = 1'b1;
    @(posedge aclk); #1;
    push(32'h5A5A_0001, 1'b0, 1'b1, 2'b00, 32'h0000_0033);
    push(32'h5A5A_0002, 1'b1, 1'b1, 2'b00, 32'h0000_0033);
    send_pkt(1, 32'h5A5A_0001, 32'h5A5A_0002, '0, 2);
    exp_cnt1++;
    drain();
    check("post_reset_pkt_cnt", 64'({pkt_cnt0, pkt_cnt1}), 64'({exp_cnt0, exp_cnt1}));

    // Counter wrap: 17 single-beat packets on a 4-bit counter starting at 0.
    cfg_mode0 = 2'b00; cfg_add0 = '0;
    for (int i = 0; i < 17; i++) begin
      push(32'h0000_0100 + DW'(i), 1'b1, 1'b0, 2'b00, '0);
      send_pkt(0, 32'h0000_0100 + DW'(i), '0, '0, 1);
      exp_cnt0++;
    end
    drain();
    check("wrap_pkt_cnt0_model", 64'(pkt_cnt0), 64'(exp_cnt0));
    check("wrap_pkt_cnt0_final", 64'(pkt_cnt0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_axis_proc_scheduler
